// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// RV32I (optionally RV32M) instruction decode stage with an elastic output
// buffer. Each instruction offered by fetch is decoded combinationally on the
// way in. The decoded record (raw fields, format, one-hot class, illegal flag,
// PC) is then written into a DEPTH-entry circular FIFO. Every out_* port shows
// the head entry of that FIFO.
//
// Parameters
//   AW    : PC width
//   DW    : instruction width (only 32 is supported)
//   EN_M  : 1 enables RV32M (func7 = 0000001 on OP) decode
//   DEPTH : buffer entries, power of two and >= 2
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : fetch-side handshake
//   in_instr, in_pc     : offered instruction and its PC
//   flush               : drop everything buffered and anything offered
//   out_valid/out_ready : consumer-side handshake on the head entry
//   out_pc              : head PC
//   out_opcode/func3/func7/rd_addr/rs1_addr/rs2_addr : raw instruction fields
//   out_fmt             : R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   out_cls             : one-hot class (int_calc, branch, load, store, jal,
//                         jalr, lui, auipc, system, muldiv, fence)
//   out_illegal         : head instruction is illegal
//   count               : current occupancy
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int EN_M  = 0,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_instr,
    input  logic [AW-1:0]            in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_pc,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_func3,
    output logic [6:0]               out_func7,
    output logic [4:0]               out_rd_addr,
    output logic [4:0]               out_rs1_addr,
    output logic [4:0]               out_rs2_addr,
    output logic [2:0]               out_fmt,
    output logic [10:0]              out_cls,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Instruction formats
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // Bit positions inside the one-hot class vector
    localparam int CLS_INT_CALC = 0;
    localparam int CLS_BRANCH   = 1;
    localparam int CLS_LOAD     = 2;
    localparam int CLS_STORE    = 3;
    localparam int CLS_JAL      = 4;
    localparam int CLS_JALR     = 5;
    localparam int CLS_LUI      = 6;
    localparam int CLS_AUIPC    = 7;
    localparam int CLS_SYSTEM   = 8;
    localparam int CLS_MULDIV   = 9;
    localparam int CLS_FENCE    = 10;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_FENCE  = 5'b00011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    // One buffered, fully decoded instruction
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [6:0]    opcode;
        logic [2:0]    func3;
        logic [6:0]    func7;
        logic [4:0]    rd_addr;
        logic [4:0]    rs1_addr;
        logic [4:0]    rs2_addr;
        logic [2:0]    fmt;
        logic [10:0]   cls;
        logic          illegal;
    } entry_t;

    // -------------------------------------------------------------------------
    // Input-side decode
    // -------------------------------------------------------------------------
    logic [4:0]  dec_op;
    logic [2:0]  dec_f3;
    logic [6:0]  dec_f7;
    logic [2:0]  dec_fmt_raw;
    logic [10:0] dec_cls_raw;
    logic        dec_illegal;
    entry_t      dec_entry;

    assign dec_op = in_instr[6:2];
    assign dec_f3 = in_instr[14:12];
    assign dec_f7 = in_instr[31:25];

    always_comb begin
        dec_fmt_raw = FMT_NONE;
        dec_cls_raw = '0;
        dec_illegal = 1'b0;

        case (dec_op)
            OP_OP: begin
                dec_fmt_raw = FMT_R;
                if (dec_f7 == F7_MULD) begin
                    // M-extension encodings are only legal when enabled
                    dec_cls_raw[CLS_MULDIV] = 1'b1;
                    dec_illegal = (EN_M == 0);
                end else if (dec_f7 == F7_ALT) begin
                    // Only SUB and SRA use the alternate func7
                    dec_cls_raw[CLS_INT_CALC] = 1'b1;
                    dec_illegal = !(dec_f3 == 3'b000 || dec_f3 == 3'b101);
                end else begin
                    dec_cls_raw[CLS_INT_CALC] = 1'b1;
                    dec_illegal = (dec_f7 != F7_ZERO);
                end
            end
            OP_OP_IMM: begin
                dec_fmt_raw = FMT_I;
                dec_cls_raw[CLS_INT_CALC] = 1'b1;
                // Shift-immediates carry func7 in imm[11:5]
                if (dec_f3 == 3'b001) begin
                    dec_illegal = (dec_f7 != F7_ZERO);
                end else if (dec_f3 == 3'b101) begin
                    dec_illegal = !(dec_f7 == F7_ZERO || dec_f7 == F7_ALT);
                end
            end
            OP_LOAD: begin
                dec_fmt_raw = FMT_I;
                dec_cls_raw[CLS_LOAD] = 1'b1;
                dec_illegal = (dec_f3 == 3'b011) || (dec_f3 == 3'b110) ||
                              (dec_f3 == 3'b111);
            end
            OP_STORE: begin
                dec_fmt_raw = FMT_S;
                dec_cls_raw[CLS_STORE] = 1'b1;
                dec_illegal = (dec_f3 > 3'b010);
            end
            OP_BRANCH: begin
                dec_fmt_raw = FMT_B;
                dec_cls_raw[CLS_BRANCH] = 1'b1;
                dec_illegal = (dec_f3 == 3'b010) || (dec_f3 == 3'b011);
            end
            OP_LUI: begin
                dec_fmt_raw = FMT_U;
                dec_cls_raw[CLS_LUI] = 1'b1;
            end
            OP_AUIPC: begin
                dec_fmt_raw = FMT_U;
                dec_cls_raw[CLS_AUIPC] = 1'b1;
            end
            OP_JAL: begin
                dec_fmt_raw = FMT_J;
                dec_cls_raw[CLS_JAL] = 1'b1;
            end
            OP_JALR: begin
                dec_fmt_raw = FMT_I;
                dec_cls_raw[CLS_JALR] = 1'b1;
                dec_illegal = (dec_f3 != 3'b000);
            end
            OP_SYSTEM: begin
                dec_fmt_raw = FMT_I;
                dec_cls_raw[CLS_SYSTEM] = 1'b1;
                if (dec_f3 == 3'b100) begin
                    dec_illegal = 1'b1;
                end else if (dec_f3 == 3'b000) begin
                    // Only ECALL (all zero) and EBREAK (imm = 1) are accepted
                    dec_illegal = (in_instr[31:7] != 25'h0000000) &&
                                  (in_instr[31:7] != 25'h0002000);
                end
            end
            OP_FENCE: begin
                dec_fmt_raw = FMT_NONE;
                dec_cls_raw[CLS_FENCE] = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Compressed or otherwise non-32-bit encodings
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
    end

    always_comb begin
        dec_entry          = '0;
        dec_entry.pc       = in_pc;
        dec_entry.opcode   = in_instr[6:0];
        dec_entry.func3    = dec_f3;
        dec_entry.func7    = dec_f7;
        dec_entry.rd_addr  = in_instr[11:7];
        dec_entry.rs1_addr = in_instr[19:15];
        dec_entry.rs2_addr = in_instr[24:20];
        dec_entry.illegal  = dec_illegal;
        // Illegal instructions carry no class and no format, but keep fields
        dec_entry.fmt      = dec_illegal ? FMT_NONE : dec_fmt_raw;
        dec_entry.cls      = dec_illegal ? 11'd0 : dec_cls_raw;
    end

    // -------------------------------------------------------------------------
    // Circular buffer control
    // -------------------------------------------------------------------------
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    // No full bypass: a pop in the same cycle does not open the input
    assign in_ready  = !full && !flush && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Power-of-two depth: natural overflow is the modulo wrap
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage holds no reset; contents are only observed while out_valid=1
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= dec_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Head presentation: an empty buffer shows the idle record so that the
    // outputs read as cleared after reset instead of exposing stale storage.
    // -------------------------------------------------------------------------
    entry_t head;

    always_comb begin
        head     = '0;
        head.fmt = FMT_NONE;
        if (out_valid) begin
            head = mem[rd_ptr_reg];
        end
    end

    assign out_pc       = head.pc;
    assign out_opcode   = head.opcode;
    assign out_func3    = head.func3;
    assign out_func7    = head.func7;
    assign out_rd_addr  = head.rd_addr;
    assign out_rs1_addr = head.rs1_addr;
    assign out_rs2_addr = head.rs2_addr;
    assign out_fmt      = head.fmt;
    assign out_cls      = head.cls;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Two decode_stage instances (EN_M=1 and EN_M=0, DEPTH=2) share one stimulus.
// A queue-based reference model tracks buffer contents and decodes the head
// from the ISA rules; every clock both instances are compared against it.
// A table of known encodings, hand-written sequences for backpressure, flush
// and reset, and a randomized phase follow.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        m_in_ready, m_out_valid, m_ill;
    logic [31:0] m_pc;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3, m_fmt;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [10:0] m_cls;
    logic [1:0]  m_count;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [31:0] b_pc;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3, b_fmt;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [10:0] b_cls;
    logic [1:0]  b_count;

    always #5 clk = ~clk;

    decode_stage #(.AW(32), .DW(32), .EN_M(1), .DEPTH(DEPTH)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_pc),
        .out_opcode(m_opc), .out_func3(m_f3), .out_func7(m_f7),
        .out_rd_addr(m_rd), .out_rs1_addr(m_rs1), .out_rs2_addr(m_rs2),
        .out_fmt(m_fmt), .out_cls(m_cls), .out_illegal(m_ill), .count(m_count)
    );

    decode_stage #(.AW(32), .DW(32), .EN_M(0), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_opcode(b_opc), .out_func3(b_f3), .out_func7(b_f7),
        .out_rd_addr(b_rd), .out_rs1_addr(b_rs1), .out_rs2_addr(b_rs2),
        .out_fmt(b_fmt), .out_cls(b_cls), .out_illegal(b_ill), .count(b_count)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    // Returns {illegal, fmt[2:0], cls[10:0]} straight from the ISA tables
    function automatic logic [14:0] ref_decode(input logic [31:0] i, input bit en_m);
        int op, f3, f7, fmt, cb;
        bit ok;
        op = int'(i[6:2]);
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        ok = (i[1:0] == 2'b11);
        fmt = 7;
        cb = 0;
        case (op)
            12: begin
                fmt = 0;
                if (f7 == 1) begin cb = 9; ok = ok && en_m; end
                else if (f7 == 32) ok = ok && (f3 == 0 || f3 == 5);
                else ok = ok && (f7 == 0);
            end
            4: begin
                fmt = 1;
                if (f3 == 1) ok = ok && (f7 == 0);
                if (f3 == 5) ok = ok && (f7 == 0 || f7 == 32);
            end
            0:  begin fmt = 1; cb = 2;  ok = ok && !(f3 inside {3, 6, 7}); end
            8:  begin fmt = 2; cb = 3;  ok = ok && (f3 <= 2); end
            24: begin fmt = 3; cb = 1;  ok = ok && !(f3 inside {2, 3}); end
            13: begin fmt = 4; cb = 6;  end
            5:  begin fmt = 4; cb = 7;  end
            27: begin fmt = 5; cb = 4;  end
            25: begin fmt = 1; cb = 5;  ok = ok && (f3 == 0); end
            28: begin
                fmt = 1; cb = 8;
                ok = ok && (f3 != 4);
                if (f3 == 0) ok = ok && (i[31:7] == 25'd0 || i[31:7] == 25'h2000);
            end
            3:  begin fmt = 7; cb = 10; end
            default: ok = 0;
        endcase
        if (!ok) return {1'b1, 3'd7, 11'd0};
        return {1'b0, 3'(fmt), 11'(1 << cb)};
    endfunction

    task automatic model_edge();
        ent_t e;
        bit do_pop, do_push;
        if (rst || flush) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            e.instr = in_instr;
            e.pc    = in_pc;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    endtask

    task automatic check_dut(input string tag, input bit en_m, input logic iready,
                             input logic ovalid, input logic [1:0] cnt,
                             input logic [31:0] pc, input logic [31:0] fields,
                             input logic [2:0] fmt, input logic [10:0] cls,
                             input logic ill);
        logic [14:0] d;
        chk({tag, ".in_ready"}, 64'(iready), 64'((q.size() < DEPTH) && !flush && !rst));
        chk({tag, ".out_valid"}, 64'(ovalid), 64'(q.size() != 0));
        chk({tag, ".count"}, 64'(cnt), 64'(q.size()));
        if (q.size() != 0) begin
            d = ref_decode(q[0].instr, en_m);
            chk({tag, ".out_pc"}, 64'(pc), 64'(q[0].pc));
            chk({tag, ".fields"}, 64'(fields), 64'(q[0].instr));
            chk({tag, ".out_fmt"}, 64'(fmt), 64'(d[13:11]));
            chk({tag, ".out_cls"}, 64'(cls), 64'(d[10:0]));
            chk({tag, ".out_illegal"}, 64'(ill), 64'(d[14]));
        end
    endtask

    // One clock: model follows the edge, then both DUTs are compared
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_dut("m", 1'b1, m_in_ready, m_out_valid, m_count, m_pc,
                  {m_f7, m_rs2, m_rs1, m_f3, m_rd, m_opc}, m_fmt, m_cls, m_ill);
        check_dut("b", 1'b0, b_in_ready, b_out_valid, b_count, b_pc,
                  {b_f7, b_rs2, b_rs1, b_f3, b_rd, b_opc}, b_fmt, b_cls, b_ill);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".m_valid"}, 64'(m_out_valid), 64'(0));
        chk({tag, ".m_count"}, 64'(m_count), 64'(0));
        chk({tag, ".m_fmt"}, 64'(m_fmt), 64'(7));
        chk({tag, ".m_cls"}, 64'(m_cls), 64'(0));
        chk({tag, ".m_ill"}, 64'(m_ill), 64'(0));
        chk({tag, ".m_fields_pc"}, 64'({m_f7, m_rs2, m_rs1, m_f3, m_rd, m_opc} | m_pc), 64'(0));
        chk({tag, ".b_fmt"}, 64'(b_fmt), 64'(7));
        chk({tag, ".b_fields_pc"}, 64'({b_f7, b_rs2, b_rs1, b_f3, b_rd, b_opc} | b_pc), 64'(0));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt_m;
        logic [10:0] cls_m;
        logic        ill_m;
        logic [2:0]  fmt_b;
        logic [10:0] cls_b;
        logic        ill_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] instr, input logic [2:0] fmt,
                           input logic [10:0] cls, input logic ill);
        vec_t v;
        v.instr = instr;
        v.fmt_m = fmt; v.cls_m = cls; v.ill_m = ill;
        v.fmt_b = fmt; v.cls_b = cls; v.ill_b = ill;
        vecs.push_back(v);
    endtask

    task automatic fill_two(input logic [31:0] base);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00108093;
        in_pc = base;        cycle();
        in_pc = base + 32'd4; cycle();
    endtask

    logic [4:0] ops [11];

    initial begin
        vec_t v;
        logic [31:0] r;

        ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b01101,
                5'b00101, 5'b11011, 5'b11001, 5'b11100, 5'b00011};

        add_vec(32'h002081B3, 3'd0, 11'h001, 1'b0); // add
        v.instr = 32'h022081B3;                     // mul: depends on EN_M
        v.fmt_m = 3'd0; v.cls_m = 11'h200; v.ill_m = 1'b0;
        v.fmt_b = 3'd7; v.cls_b = 11'h000; v.ill_b = 1'b1;
        vecs.push_back(v);
        add_vec(32'h40208133, 3'd0, 11'h001, 1'b0); // sub
        add_vec(32'h40209133, 3'd7, 11'h000, 1'b1); // alt func7 on sll
        add_vec(32'hFE2081B3, 3'd7, 11'h000, 1'b1); // bad func7
        add_vec(32'h00108093, 3'd1, 11'h001, 1'b0); // addi
        add_vec(32'h02109093, 3'd7, 11'h000, 1'b1); // slli bad func7
        add_vec(32'h4010D093, 3'd1, 11'h001, 1'b0); // srai
        add_vec(32'h00012083, 3'd1, 11'h004, 1'b0); // lw
        add_vec(32'h00013083, 3'd7, 11'h000, 1'b1); // ld
        add_vec(32'h00112023, 3'd2, 11'h008, 1'b0); // sw
        add_vec(32'h00113023, 3'd7, 11'h000, 1'b1); // sd
        add_vec(32'h00208063, 3'd3, 11'h002, 1'b0); // beq
        add_vec(32'h0020A063, 3'd7, 11'h000, 1'b1); // branch f3=010
        add_vec(32'h000010B7, 3'd4, 11'h040, 1'b0); // lui
        add_vec(32'h00001097, 3'd4, 11'h080, 1'b0); // auipc
        add_vec(32'h0000006F, 3'd5, 11'h010, 1'b0); // jal
        add_vec(32'h00008067, 3'd1, 11'h020, 1'b0); // jalr
        add_vec(32'h00009067, 3'd7, 11'h000, 1'b1); // jalr f3=001
        add_vec(32'h00000073, 3'd1, 11'h100, 1'b0); // ecall
        add_vec(32'h00100073, 3'd1, 11'h100, 1'b0); // ebreak
        add_vec(32'h30001073, 3'd1, 11'h100, 1'b0); // csrrw
        add_vec(32'h00004073, 3'd7, 11'h000, 1'b1); // system f3=100
        add_vec(32'h10200073, 3'd7, 11'h000, 1'b1); // sret not accepted
        add_vec(32'h0000F00F, 3'd7, 11'h400, 1'b0); // fence f3=111
        add_vec(32'h00000000, 3'd7, 11'h000, 1'b1); // all zero
        add_vec(32'h00000011, 3'd7, 11'h000, 1'b1); // low bits != 11
        add_vec(32'h0000007F, 3'd7, 11'h000, 1'b1); // unlisted opcode

        // Reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_instr = 32'h002081B3; in_pc = 32'h40;
        cycle(); cycle();
        check_reset_vals("reset");
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(m_in_ready), 64'(1));

        // Single push into empty buffer: add x3,x1,x2
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        cycle();
        chk("single.valid", 64'(m_out_valid), 64'(1));
        chk("single.fmt", 64'(m_fmt), 64'(0));
        chk("single.cls", 64'(m_cls), 64'(11'h001));
        chk("single.regs", 64'({m_rd, m_rs1, m_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("single.ill", 64'(m_ill), 64'(0));
        chk("single.pc", 64'(m_pc), 64'(32'h100));
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();

        // Table: stream with push+pop each cycle; head is the latest push
        out_ready = 1'b1; in_valid = 1'b1;
        foreach (vecs[i]) begin
            in_instr = vecs[i].instr;
            in_pc = 32'h1000 + 32'(i * 4);
            cycle();
            chk($sformatf("vec%0d.m.fmt", i), 64'(m_fmt), 64'(vecs[i].fmt_m));
            chk($sformatf("vec%0d.m.cls", i), 64'(m_cls), 64'(vecs[i].cls_m));
            chk($sformatf("vec%0d.m.ill", i), 64'(m_ill), 64'(vecs[i].ill_m));
            chk($sformatf("vec%0d.b.fmt", i), 64'(b_fmt), 64'(vecs[i].fmt_b));
            chk($sformatf("vec%0d.b.cls", i), 64'(b_cls), 64'(vecs[i].cls_b));
            chk($sformatf("vec%0d.b.ill", i), 64'(b_ill), 64'(vecs[i].ill_b));
            chk($sformatf("vec%0d.count", i), 64'(m_count), 64'(1));
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure: three offers with out_ready low, then drain
        fill_two(32'h200);
        chk("bp.count_full", 64'(m_count), 64'(2));
        chk("bp.in_ready_full", 64'(m_in_ready), 64'(0));
        in_pc = 32'h208;
        cycle();
        chk("bp.third_held", 64'(m_count), 64'(2));
        chk("bp.head0", 64'(m_pc), 64'(32'h200));
        out_ready = 1'b1;
        cycle();
        chk("bp.pop_full_count", 64'(m_count), 64'(1));
        chk("bp.head1", 64'(m_pc), 64'(32'h204));
        cycle();
        chk("bp.pushpop_count", 64'(m_count), 64'(1));
        chk("bp.head2", 64'(m_pc), 64'(32'h208));
        in_valid = 1'b0;
        cycle();
        chk("bp.drained", 64'(m_out_valid), 64'(0));

        // Flush with a concurrent offer
        fill_two(32'h400);
        flush = 1'b1; in_pc = 32'hDEAD0; in_instr = 32'h00000073;
        cycle();
        chk("flush.count", 64'(m_count), 64'(0));
        chk("flush.valid", 64'(m_out_valid), 64'(0));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("flush.no_ghost%0d", k), 64'(b_out_valid), 64'(0));
        end

        // Reset mid-operation
        fill_two(32'h600);
        rst = 1'b1; in_pc = 32'hBAD;
        cycle();
        check_reset_vals("midrst");
        chk("midrst.in_ready", 64'(m_in_ready), 64'(0));
        rst = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h00000073;
        #1;
        chk("midrst.ready_after", 64'(m_in_ready), 64'(1));
        cycle();
        chk("midrst.first_valid", 64'(m_out_valid), 64'(1));
        chk("midrst.first_pc", 64'(m_pc), 64'(32'h300));
        chk("midrst.first_cls", 64'(m_cls), 64'(11'h100));

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                r[1:0] = 2'b11;
                r[6:2] = ops[$urandom_range(0, 10)];
            end
            if ($urandom_range(0, 2) == 0) r = vecs[$urandom_range(0, vecs.size() - 1)].instr;
            in_instr  = r;
            in_pc     = $urandom();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL provide parameter AW, default 32, meaning PC width.
REQ-002 SHALL provide parameter DW, default 32, meaning instruction width; only 32 is supported.
REQ-003 SHALL provide parameter EN_M, default 0, meaning 1 enables RV32M decode.
REQ-004 SHALL provide parameter DEPTH, default 2, meaning output buffer entries; it must be a power of 2 and at least 2.
REQ-005 SHALL provide ports as listed; the block uses one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts
- in_instr  in  DW  instruction word
- in_pc  in  AW  instruction PC
- flush  in  1  discard all buffered and offered instructions
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_pc  out  AW  head PC
- out_opcode / out_func3 / out_func7  out  7/3/7  fields instr[6:0], [14:12], [31:25]
- out_rd_addr / out_rs1_addr / out_rs2_addr  out  5 each  fields [11:7], [19:15], [24:20]
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_cls  out  11  one-hot class: [0]int_calc [1]branch [2]load [3]store [4]jal [5]jalr [6]lui [7]auipc [8]system [9]muldiv [10]fence
- out_illegal  out  1  head instruction is illegal
- count  out  $clog2(DEPTH)+1  occupancy

Function
REQ-006 SHALL decode in_instr combinationally at the input and store the decoded fields, fmt, cls, illegal flag and PC in a DEPTH-entry circular FIFO; all out_* signals SHALL be driven from the head entry registers.
REQ-007 SHALL assert in_ready = !full && !flush; push occurs on in_valid && in_ready.
REQ-008 SHALL pop on out_valid && out_ready; out_valid = (count != 0).
REQ-009 SHALL have a latency of 1 cycle: an instruction pushed at edge N into an empty FIFO is presented with out_valid=1 after edge N.
REQ-010 SHALL perform push and pop in the same cycle (count unchanged) whenever both are legal; when full, in_ready stays 0 even if a pop occurs (no full bypass).
REQ-011 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-012 SHALL, when flush=1, set count, rd_ptr and wr_ptr to 0 at the next edge, discard any concurrent push, and ignore out_ready.
REQ-013 SHALL classify by instr[6:2]: 01100 R/int_calc; 00100 I/int_calc; 00000 I/load; 01000 S/store; 11000 B/branch; 01101 U/lui; 00101 U/auipc; 11011 J/jal; 11001 I/jalr; 11100 I/system; 00011 NONE/fence.
REQ-014 SHALL treat R-type with func7=0000001 as muldiv (cls[9], not cls[0]) when EN_M=1, and as illegal when EN_M=0.
REQ-015 SHALL flag illegal for any of:
- instr[1:0] != 11, or an unlisted opcode
- R-type with func7 not in {0000000, 0100000, 0000001}
- R-type with func7=0100000 and func3 not in {000, 101}
- I-calc func3=001 with func7 != 0
- I-calc func3=101 with func7 not in {0000000, 0100000}
- branch func3 in {010, 011}
- load func3 in {011, 110, 111}
- store func3 > 010
- jalr func3 != 000
- system func3=100
- system func3=000 with instr[31:7] not in {0, 0x2000}
REQ-016 SHALL, for an illegal instruction, set out_illegal=1, out_cls=0 and out_fmt=NONE; raw fields and PC SHALL still be passed through, and the entry SHALL be buffered and handshaked normally.

Reset
REQ-017 SHALL, while rst=1 at an edge, clear pointers and count, drive out_valid=0, in_ready=0, out_illegal=0, out_cls=0, out_fmt=NONE and all field outputs to 0.
REQ-018 SHALL give rst priority over flush and all handshakes; an instruction offered during reset is discarded.
REQ-019 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-020 Single push, empty FIFO: in_instr=0x002081B3 (add x3,x1,x2), pc=0x100 -> next cycle out_valid=1, fmt=0, cls=0x001, rd=3, rs1=1, rs2=2, out_illegal=0.
REQ-021 EN_M variants: instr 0x022081B3 -> EN_M=1 gives cls=0x200, illegal=0; EN_M=0 gives illegal=1, cls=0.
REQ-022 Backpressure with DEPTH=2: push 3 back-to-back with out_ready=0 -> in_ready=0 after 2 pushes, count=2; raise out_ready -> entries emerge in order; a simultaneous push/pop keeps count=1.
REQ-023 Flush mid-stream: count=2 and flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; the offered instruction never appears at the output.
REQ-024 Illegal/system coverage: 0x00000000 -> illegal; 0x00000073 (ecall) -> cls=0x100, legal; 0x00100073 (ebreak) -> legal; 0x0000F00F (fence, func3=111) -> cls=0x400.
REQ-025 Reset mid-operation: count=2, then rst=1 for 1 cycle -> out_valid=0, count=0, all outputs at reset values; first push after reset emerges with 1-cycle latency.
